// File: rtl/shift_register_pkg.sv
// Shared types for the parallel-to-serial shift register: FSM encoding and
// the beat-counter width helper.
package shift_register_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Counter must hold BEATS itself, hence +1.
   function automatic int beat_cnt_width(input int beats);
      return $clog2(beats + 1);
   endfunction

endpackage

// File: rtl/shift_register_holding_reg.sv
// One-entry valid/ready holding register that parks the next word while the
// current one is still being serialised.
module shift_register_holding_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data
);

   logic             full;
   logic [WIDTH-1:0] word;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full <= 1'b0;
         word <= '0;
      end else begin
         // Write only when empty and read only when full, so the two never collide.
         full <= (full && !rd_ready) || (wr_valid && !full);
         if (wr_valid && !full) begin
            word <= wr_data;
         end
      end
   end

   assign wr_ready = !full;
   assign rd_valid = full;
   assign rd_data  = word;

endmodule

// File: rtl/shift_register_serializer.sv
// Parallel-to-serial shift register with valid/ready on both sides.
// Define SHIFT_REGISTER_SERIALIZER_PRELOAD_EN to add a one-word holding register for gapless streaming.
//
// state | meaning
// IDLE  | no word loaded, out_valid_o low, data_o all FILL_VALUE
// SHIFT | word loaded, presenting beats until the final-beat handshake
module shift_register_serializer
   import shift_register_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter int   LANES      = 1,
   parameter bit   MSB_FIRST  = 1'b0,
   parameter logic FILL_VALUE = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] value_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [LANES-1:0] data_o,
   output logic             last_o,
   output logic             busy_o
);

   localparam int BEATS = WIDTH / LANES;
   localparam int CW    = beat_cnt_width(BEATS);
   localparam logic [WIDTH-1:0] FILL_WORD = {WIDTH{FILL_VALUE}};
   localparam logic [WIDTH-1:0] ONES      = '1;
   localparam logic [WIDTH-1:0] VACATED   = MSB_FIRST ? ~(ONES << LANES) : ~(ONES >> LANES);

   generate
      if (LANES < 1 || LANES > WIDTH || (WIDTH % LANES) != 0) begin : g_bad_cfg
         $error("shift_register_serializer: LANES must divide WIDTH and lie in 1..WIDTH");
      end
   endgenerate

   state_t           state, state_n;
   logic [WIDTH-1:0] shift, shift_n, shifted;
   logic [CW-1:0]    cnt, cnt_n;
   logic             last, last_n;
   logic             fire_in, fire_out, final_beat, can_take;
   logic             load;
   logic [WIDTH-1:0] load_word;

   assign fire_in    = in_valid_i && in_ready_o;
   assign fire_out   = out_valid_o && out_ready_i;
   assign final_beat = fire_out && last;
   assign can_take   = (state == IDLE) || final_beat;

   // After BEATS shifts the register is all FILL_VALUE, so idle data_o needs no mux.
   assign shifted = MSB_FIRST ? ((shift << LANES) | (FILL_WORD & VACATED))
                              : ((shift >> LANES) | (FILL_WORD & VACATED));

`ifdef SHIFT_REGISTER_SERIALIZER_PRELOAD_EN
   logic             hold_wr_ready;
   logic             hold_valid;
   logic [WIDTH-1:0] hold_data;

   // A word arriving when the shifter can take it bypasses the holding register.
   shift_register_holding_reg #(.WIDTH(WIDTH)) u_hold (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wr_valid (in_valid_i && !can_take),
      .wr_ready (hold_wr_ready),
      .wr_data  (value_i),
      .rd_valid (hold_valid),
      .rd_ready (can_take),
      .rd_data  (hold_data)
   );

   assign in_ready_o = hold_wr_ready;
   assign load       = (hold_valid || fire_in) && can_take;
   assign load_word  = hold_valid ? hold_data : value_i;
`else
   logic rdy, rdy_n;

   assign in_ready_o = rdy;
   assign load       = fire_in;
   assign load_word  = value_i;
   assign rdy_n      = (state_n == IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdy <= 1'b1;
      end else begin
         rdy <= rdy_n;
      end
   end
`endif

   always_comb begin
      state_n = state;
      shift_n = shift;
      cnt_n   = cnt;
      if (load) begin
         state_n = SHIFT;
         shift_n = load_word;
         cnt_n   = CW'(BEATS);
      end else if (fire_out) begin
         shift_n = shifted;
         cnt_n   = cnt - CW'(1);
         if (last) begin
            state_n = IDLE;
         end
      end
      last_n = (state_n == SHIFT) && (cnt_n == CW'(1));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         shift <= FILL_WORD;
         cnt   <= '0;
         last  <= 1'b0;
      end else begin
         state <= state_n;
         shift <= shift_n;
         cnt   <= cnt_n;
         last  <= last_n;
      end
   end

   assign out_valid_o = (state == SHIFT);
   assign busy_o      = (state == SHIFT);
   assign last_o      = last;
   assign data_o      = MSB_FIRST ? shift[WIDTH-1 -: LANES] : shift[LANES-1:0];

endmodule

// File: tb/tb_shift_register_serializer.sv
// Scoreboard bench: three serializer configurations, expected beats queued at
// each input handshake and compared whenever a beat is presented.
module tb_shift_register_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_last, a_busy;
   logic [7:0] a_value;
   logic [0:0] a_data;
   logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_last, b_busy;
   logic [7:0] b_value;
   logic [1:0] b_data;
   logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_last, c_busy;
   logic [7:0] c_value;
   logic [3:0] c_data;

   shift_register_serializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0), .FILL_VALUE(1'b0)) u_a (
      .clk_i(clk), .rst_i(rst), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
      .value_i(a_value), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
      .data_o(a_data), .last_o(a_last), .busy_o(a_busy));

   shift_register_serializer #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b1), .FILL_VALUE(1'b1)) u_b (
      .clk_i(clk), .rst_i(rst), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
      .value_i(b_value), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
      .data_o(b_data), .last_o(b_last), .busy_o(b_busy));

   shift_register_serializer #(.WIDTH(8), .LANES(4), .MSB_FIRST(1'b0), .FILL_VALUE(1'b0)) u_c (
      .clk_i(clk), .rst_i(rst), .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
      .value_i(c_value), .out_valid_o(c_out_valid), .out_ready_i(c_out_ready),
      .data_o(c_data), .last_o(c_last), .busy_o(c_busy));

   typedef struct {
      logic [3:0] data;
      logic       last;
   } beat_t;

   beat_t qa[$], qb[$], qc[$];
   int    n_chk  = 0;
   int    n_fail = 0;
   int    a_beats = 0, a_lasts = 0;
   int    c_hs = 0, c_t0 = 0, c_t3 = 0;
   int    cyc = 0;
   int    done = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] beat_of(input logic [7:0] w, input int lanes, input bit msb, input int b);
      logic [7:0] t;
      if (msb) t = w >> (8 - (b + 1) * lanes);
      else     t = w >> (b * lanes);
      return 4'(int'(t) & ((1 << lanes) - 1));
   endfunction

   function automatic void expect_word(input int d, input logic [7:0] w);
      int lanes;
      lanes = (d == 0) ? 1 : (d == 1) ? 2 : 4;
      for (int b = 0; b < 8 / lanes; b++) begin
         beat_t e;
         e.data = beat_of(w, lanes, d == 1, b);
         e.last = (b == 8 / lanes - 1);
         case (d)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
         endcase
      end
   endfunction

   function automatic int qsize(input int d);
      case (d)
         0:       return qa.size();
         1:       return qb.size();
         default: return qc.size();
      endcase
   endfunction

   function automatic logic rdy_of(input int d);
      case (d)
         0:       return a_in_ready;
         1:       return b_in_ready;
         default: return c_in_ready;
      endcase
   endfunction

   task automatic drive(input int d, input logic v, input logic [7:0] w);
      case (d)
         0:       begin a_in_valid = v; a_value = w; end
         1:       begin b_in_valid = v; b_value = w; end
         default: begin c_in_valid = v; c_value = w; end
      endcase
   endtask

   // Holds in_valid until the DUT shows ready; the handshake lands on the following edge.
   task automatic send(input int d, input logic [7:0] w);
      int t;
      t = 0;
      drive(d, 1'b1, w);
      @(negedge clk);
      while (!rdy_of(d) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!rdy_of(d)) chk("accept_timeout", 32'(rdy_of(d)), 1);
      else            expect_word(d, w);
      @(posedge clk);
      #1;
      drive(d, 1'b0, w);
   endtask

   task automatic drain(input int d);
      int t;
      t = 0;
      while (qsize(d) != 0 && t < 500) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain", qsize(d), 0);
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rst) begin
         if (a_out_valid) begin
            chk("a_busy", a_busy, 1);
            if (qa.size() == 0) chk("a_spurious", a_out_valid, 0);
            else begin
               chk("a_data", a_data, qa[0].data);
               chk("a_last", a_last, qa[0].last);
               if (a_out_ready) begin
                  void'(qa.pop_front());
                  a_beats++;
                  if (a_last) a_lasts++;
               end
            end
         end else begin
            chk("a_idle_data", a_data, 0);
            chk("a_idle_last", a_last, 0);
            chk("a_idle_busy", a_busy, 0);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (b_out_valid) begin
            if (qb.size() == 0) chk("b_spurious", b_out_valid, 0);
            else begin
               chk("b_data", b_data, qb[0].data);
               chk("b_last", b_last, qb[0].last);
               if (b_out_ready) void'(qb.pop_front());
            end
         end else begin
            chk("b_idle_data", b_data, 2'b11);
            chk("b_idle_last", b_last, 0);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (c_out_valid) begin
            if (qc.size() == 0) chk("c_spurious", c_out_valid, 0);
            else begin
               chk("c_data", c_data, qc[0].data);
               chk("c_last", c_last, qc[0].last);
               if (c_out_ready) begin
                  void'(qc.pop_front());
                  if (c_hs == 0) c_t0 = cyc;
                  if (c_hs == 3) c_t3 = cyc;
                  c_hs++;
               end
            end
         end else begin
            chk("c_idle_data", c_data, 0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base;
      int t;
      rst = 1'b1;
      a_in_valid = 0; a_value = '0; a_out_ready = 0;
      b_in_valid = 0; b_value = '0; b_out_ready = 0;
      c_in_valid = 0; c_value = '0; c_out_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("a_rst_ready", a_in_ready, 1);
      chk("a_rst_valid", a_out_valid, 0);
      chk("b_rst_data", b_data, 2'b11);
      chk("c_rst_ready", c_in_ready, 1);
      @(posedge clk);
      #1;

      // LSB-first single lane, sink always ready.
      a_out_ready = 1;
      base = a_beats;
      send(0, 8'hA5);
      drain(0);
      chk("a5_beats", a_beats - base, 8);
      @(negedge clk);
      chk("a5_busy_after", a_busy, 0);
      @(posedge clk);
      #1;

      // MSB-first, two lanes, FILL_VALUE=1.
      b_out_ready = 1;
      send(1, 8'hC6);
      drain(1);

      // Stall pattern 1,0,0,1 while a word is in flight.
      base = a_beats;
      fork
         send(0, 8'h5A);
         begin
            for (int i = 0; i < 24; i++) begin
               a_out_ready = (i % 4 == 0) || (i % 4 == 3);
               @(posedge clk);
               #1;
            end
            a_out_ready = 1;
         end
      join
      drain(0);
      chk("stall_beats", a_beats - base, 8);

      // Back-to-back words on the four-lane instance.
      c_out_ready = 1;
      send(2, 8'h0F);
      send(2, 8'hF0);
      drain(2);
      chk("c_beat_count", c_hs, 4);
`ifdef SHIFT_REGISTER_SERIALIZER_PRELOAD_EN
      chk("c_span", c_t3 - c_t0, 3);
`else
      chk("c_span", c_t3 - c_t0, 4);
`endif

      // Reset after the third beat of 0xA5 aborts the word.
      a_out_ready = 1;
      base = a_beats;
      send(0, 8'hA5);
      t = 0;
      while (a_beats < base + 3 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("pre_reset_beats", a_beats - base, 3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      qa.delete();
      @(negedge clk);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_data", a_data, 0);
      chk("rst_last", a_last, 0);
      @(posedge clk);
      #1;
      base = a_beats;
      send(0, 8'h3C);
      drain(0);
      chk("post_reset_beats", a_beats - base, 8);

      // Random valid/ready stress against the scoreboard.
      base = a_lasts;
      done = 0;
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk);
                  #1;
               end
               send(0, 8'($urandom));
            end
            done = 1;
         end
         begin
            while (done == 0) begin
               a_out_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      a_out_ready = 1;
      drain(0);
      chk("stress_last_count", a_lasts - base, 40);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_register_serializer.md
SHIFT_REGISTER_SERIALIZER -- requirements
Module: shift_register_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits.
REQ-002 Parameter LANES, default 1: bits emitted per output beat. WIDTH % LANES shall be 0 and 1 <= LANES <= WIDTH; violation is an elaboration error.
REQ-003 Parameter MSB_FIRST, default 0: 0 emits LSBs first, 1 emits MSBs first.
REQ-004 Parameter FILL_VALUE, default 1'b0: bit shifted into vacated positions and driven on data_o when idle.
REQ-005 clk_i  input  1  system clock; single clock domain.
REQ-006 rst_i  input  1  synchronous, active-high reset.
REQ-007 in_valid_i  input  1  value_i holds a word to load.
REQ-008 in_ready_o  output  1  block can accept a word this cycle.
REQ-009 value_i  input  WIDTH  parallel word, sampled only on input handshake.
REQ-010 out_valid_o  output  1  data_o holds a valid beat.
REQ-011 out_ready_i  input  1  sink consumes the beat this cycle.
REQ-012 data_o  output  LANES  current beat.
REQ-013 last_o  output  1  current beat is the final beat of its word.
REQ-014 busy_o  output  1  a word is being serialised (out_valid_o high).

Function
REQ-015 Input handshake = in_valid_i && in_ready_o at a rising edge; output handshake = out_valid_o && out_ready_i.
REQ-016 BEATS = WIDTH/LANES; each accepted word produces exactly BEATS output beats, in order, with no loss or duplication.
REQ-017 Latency: word accepted at edge N is presented (out_valid_o=1, first beat on data_o) from the cycle after edge N.
REQ-018 MSB_FIRST=0: data_o = shift[LANES-1:0]; each output handshake shifts right by LANES, filling with FILL_VALUE.
REQ-019 MSB_FIRST=1: data_o = shift[WIDTH-1 -: LANES]; each output handshake shifts left by LANES, filling with FILL_VALUE.
REQ-020 While out_valid_o && !out_ready_i, data_o, last_o and the internal word shall hold stable.
REQ-021 Beat counter width $clog2(BEATS+1); last_o high only when remaining count is 1; BEATS=1 means last_o high on every beat.
REQ-022 State machine: IDLE (out_valid_o=0) -> SHIFT on input handshake; SHIFT -> SHIFT on non-final output handshake; SHIFT -> IDLE on final-beat handshake with no word pending; SHIFT -> SHIFT (reload) on final-beat handshake with a word pending.
REQ-023 In IDLE, data_o shall be all FILL_VALUE and last_o 0.
REQ-024 All outputs shall be registered; no combinational path from out_ready_i or in_valid_i to any output.

Reset
REQ-025 rst_i has priority over all handshakes; next cycle: out_valid_o=0, last_o=0, busy_o=0, in_ready_o=1, data_o=all FILL_VALUE, counter=0, pending word discarded.
REQ-026 Reset mid-word shall abort the word; no further beats of it shall appear.

Configuration
REQ-027 Macro SHIFT_REGISTER_SERIALIZER_PRELOAD_EN: when defined, a one-word holding register is compiled in; in_ready_o = holding register empty; a word in the holding register is loaded at the final-beat handshake so consecutive words stream with zero idle cycles.
REQ-028 Without the macro: in_ready_o = (state==IDLE); after a final-beat handshake one IDLE cycle occurs before the next word can be accepted.

Structure
REQ-029 Package shift_register_pkg shall hold the state encoding (IDLE, SHIFT) and a beat-count width helper function.
REQ-030 Holding register shall be a sub-module shift_register_holding_reg (valid/ready, one entry), instantiated only under the macro.

Verification
REQ-031 WIDTH=8,LANES=1,MSB_FIRST=0, load 0xA5, out_ready_i=1 -> data_o sequence 1,0,1,0,0,1,0,1; last_o on 8th beat only; busy_o drops next cycle.
REQ-032 WIDTH=8,LANES=2,MSB_FIRST=1, load 0xC6 -> beats 3,0,1,2; last_o on 4th.
REQ-033 out_ready_i toggled 1,0,0,1 mid-word -> data_o/last_o frozen during stalls; total beats still BEATS.
REQ-034 Back-to-back words 0x0F,0xF0 (LANES=4): with macro 4 consecutive valid beats F,0,0,F; without macro one gap cycle between words.
REQ-035 rst_i asserted after beat 3 of 0xA5 -> next cycle out_valid_o=0, in_ready_o=1, data_o=FILL_VALUE; new word 0x3C then serialises correctly from beat 1.
REQ-036 Random valid/ready stress vs scoreboard -> every word reconstructed exactly, last_o count = word count.
